// File: rtl/mc_cpu_ctrl.sv
// mc_cpu_ctrl: multicycle MIPS-subset control FSM; define MC_SINGLE_STEP_EN to add a step input that gates IF
module mc_cpu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zf,
`ifdef MC_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal,
  output logic       done
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EX_R = 4'd2, S_EX_I = 4'd3, S_MA = 4'd4, S_MRD = 4'd5,
    S_MWR = 4'd6, S_WB_R = 4'd7, S_WB_I = 4'd8, S_WB_L = 4'd9, S_BR = 4'd10, S_JMP = 4'd11
  } state_t;
  state_t cur, nxt, id_nxt;
  logic go, r_ok, id_bad, ill_q;
  logic [2:0] r_alu, i_alu;
`ifdef MC_SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif
  assign state = cur;
  assign illegal = ill_q;
  assign id_bad = (id_nxt == S_IF);
  always_comb begin
    r_ok = 1'b1;
    case (funct)
      6'b100000: r_alu = 3'b100;
      6'b100010: r_alu = 3'b101;
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      6'b100110: r_alu = 3'b010;
      6'b100111: r_alu = 3'b011;
      6'b101011: r_alu = 3'b110;
      6'b000100: r_alu = 3'b111;
      default: begin
        r_alu = 3'b000;
        r_ok = 1'b0;
      end
    endcase
  end
  always_comb begin
    i_alu = 3'b100;
    id_nxt = S_IF;
    case (op)
      6'b000000: id_nxt = r_ok ? S_EX_R : S_IF;
      6'b001000: id_nxt = S_EX_I;
      6'b001011: begin
        id_nxt = S_EX_I;
        i_alu = 3'b110;
      end
      6'b001100: begin
        id_nxt = S_EX_I;
        i_alu = 3'b000;
      end
      6'b001101: begin
        id_nxt = S_EX_I;
        i_alu = 3'b001;
      end
      6'b001110: begin
        id_nxt = S_EX_I;
        i_alu = 3'b010;
      end
      6'b100011, 6'b101011: id_nxt = S_MA;
      6'b000100, 6'b000101: id_nxt = S_BR;
      6'b000010: id_nxt = S_JMP;
      default: id_nxt = S_IF;
    endcase
  end
  always_comb begin
    nxt = S_IF;
    pc_write = 1'b0;
    ir_write = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    pc_src = 2'b00;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 3'b000;
    done = 1'b0;
    if (!rst) begin
      case (cur)
        S_IF: if (go) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          alu_src_b = 2'b01;
          alu_op = 3'b100;
          nxt = S_ID;
        end
        S_ID: begin
          nxt = id_nxt;
          done = id_bad;
        end
        S_EX_R: begin
          alu_src_a = 1'b1;
          alu_op = r_alu;
          nxt = S_WB_R;
        end
        S_EX_I: begin
          alu_src_a = 1'b1;
          alu_src_b = (op == 6'b001000 || op == 6'b001011) ? 2'b10 : 2'b11;
          alu_op = i_alu;
          nxt = S_WB_I;
        end
        S_MA: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op = 3'b100;
          nxt = op[3] ? S_MWR : S_MRD;
        end
        S_MRD: nxt = S_WB_L;
        S_MWR: begin
          mem_write = 1'b1;
          done = 1'b1;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
          done = 1'b1;
        end
        S_WB_I: begin
          reg_write = 1'b1;
          done = 1'b1;
        end
        S_WB_L: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
          done = 1'b1;
        end
        S_BR: begin
          alu_src_a = 1'b1;
          alu_op = 3'b101;
          pc_src = 2'b01;
          pc_write = op[0] ? ~zf : zf;
          done = 1'b1;
        end
        S_JMP: begin
          pc_write = 1'b1;
          pc_src = 2'b10;
          done = 1'b1;
        end
        default: nxt = S_IF;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    cur <= rst ? S_IF : nxt;
    ill_q <= rst ? 1'b0 : (ill_q | (cur == S_ID && id_bad));
  end
endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// tb_mc_cpu_ctrl: scoreboard bench for mc_cpu_ctrl; random instructions against a per-instruction retire model
module tb_mc_cpu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zf = 1'b0;
`ifdef MC_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  logic pc_write, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal, done;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  always #5 clk = ~clk;
  mc_cpu_ctrl dut (
    .clk(clk),
    .rst(rst),
    .op(op),
    .funct(funct),
    .zf(zf),
`ifdef MC_SINGLE_STEP_EN
    .step(step),
`endif
    .pc_write(pc_write),
    .ir_write(ir_write),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .pc_src(pc_src),
    .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .state(state),
    .illegal(illegal),
    .done(done)
  );
  typedef struct packed {
    logic [4:0][3:0] st;
    logic [2:0] n;
    logic [2:0] alu;
    logic [2:0] rw;
    logic [2:0] mw;
    logic [2:0] m2r;
    logic [2:0] irw;
    logic pcw;
    logic [1:0] pcs;
    logic rd;
    logic ill;
  } rec_t;
  rec_t q[$];
  int total = 0;
  int bad = 0;
  logic sticky = 1'b0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [3:0] rfun(logic [5:0] f);
    case (f)
      6'h20: return 4'b1100;
      6'h22: return 4'b1101;
      6'h24: return 4'b1000;
      6'h25: return 4'b1001;
      6'h26: return 4'b1010;
      6'h27: return 4'b1011;
      6'h2B: return 4'b1110;
      6'h04: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction
  function automatic rec_t model(logic [5:0] o, logic [5:0] f, logic z, logic ill);
    rec_t r;
    logic [3:0] rv;
    r = '0;
    r.ill = ill;
    r.irw = 3'd1;
    r.st[1] = 4'd1;
    r.n = 3'd2;
    rv = rfun(f);
    if (o == 6'h00 && rv[3]) begin
      r.st[2] = 4'd2; r.st[3] = 4'd7; r.n = 3'd4; r.alu = rv[2:0]; r.rw = 3'd1; r.rd = 1'b1;
    end else if (o == 6'h08 || o == 6'h0B || o == 6'h0C || o == 6'h0D || o == 6'h0E) begin
      r.st[2] = 4'd3; r.st[3] = 4'd8; r.n = 3'd4; r.rw = 3'd1;
      r.alu = (o == 6'h08) ? 3'b100 : (o == 6'h0B) ? 3'b110 : (o == 6'h0C) ? 3'b000 : (o == 6'h0D) ? 3'b001 : 3'b010;
    end else if (o == 6'h23) begin
      r.st[2] = 4'd4; r.st[3] = 4'd5; r.st[4] = 4'd9; r.n = 3'd5; r.alu = 3'b100; r.rw = 3'd1; r.m2r = 3'd1;
    end else if (o == 6'h2B) begin
      r.st[2] = 4'd4; r.st[3] = 4'd6; r.n = 3'd4; r.alu = 3'b100; r.mw = 3'd1;
    end else if (o == 6'h04 || o == 6'h05) begin
      r.st[2] = 4'd10; r.n = 3'd3; r.alu = 3'b101; r.pcs = 2'b01; r.pcw = (o == 6'h04) ? z : ~z;
    end else if (o == 6'h02) begin
      r.st[2] = 4'd11; r.n = 3'd3; r.pcs = 2'b10; r.pcw = 1'b1;
    end
    return r;
  endfunction
  initial begin
    rec_t ob, e;
    ob = '0;
    forever begin
      @(negedge clk);
      if (rst) ob = '0;
      else begin
        if (state == 4'd0) begin
          ob = '0;
          ob.ill = illegal;
        end
        if (ob.n == 3'd2) ob.alu = alu_op;
        if (ob.n < 3'd5) begin
          ob.st[ob.n] = state;
          ob.n = ob.n + 3'd1;
        end
        ob.rw = ob.rw + 3'(reg_write);
        ob.mw = ob.mw + 3'(mem_write);
        ob.m2r = ob.m2r + 3'(mem_to_reg);
        ob.irw = ob.irw + 3'(ir_write);
        if (done) begin
          ob.pcw = pc_write;
          ob.pcs = pc_src;
          ob.rd = reg_dst;
          if (q.size() == 0) chk("spurious_done", done, 0);
          else begin
            e = q.pop_front();
            chk("state_trace", ob.st, e.st);
            chk("cycles", ob.n, e.n);
            if (e.n >= 3'd3) chk("alu_op_exec", ob.alu, e.alu);
            chk("reg_write_cycles", ob.rw, e.rw);
            chk("mem_write_cycles", ob.mw, e.mw);
            chk("mem_to_reg_cycles", ob.m2r, e.m2r);
            chk("ir_write_cycles", ob.irw, e.irw);
            chk("pc_write_at_done", ob.pcw, e.pcw);
            chk("pc_src_at_done", ob.pcs, e.pcs);
            chk("reg_dst_at_done", ob.rd, e.rd);
            chk("illegal_at_if", ob.ill, e.ill);
          end
        end
      end
    end
  end
  task automatic wait_retire();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge clk);
    chk("retire_timeout", q.size(), 0);
    q.delete();
    #1;
  endtask
  task automatic run(logic [5:0] o, logic [5:0] f, logic z);
    rec_t e;
    op = o;
    funct = f;
    zf = z;
    e = model(o, f, z, sticky);
    q.push_back(e);
    if (e.n == 3'd2) sticky = 1'b1;
    wait_retire();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_enables", {pc_write, ir_write, mem_write, reg_write, done}, 0);
    chk("rst_selects", {pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sticky = 1'b0;
    q.delete();
    chk("rst_state", state, 0);
    chk("rst_illegal", illegal, 0);
  endtask
  logic [5:0] ops [11] = '{6'h00, 6'h08, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04};
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [5:0] o, f;
    do_reset();
`ifdef MC_SINGLE_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("step_hold_state", state, 0);
      chk("step_hold_pcw", pc_write, 0);
    end
    op = 6'h02;
    q.push_back(model(6'h02, 6'h00, 1'b0, sticky));
    step = 1'b1;
    #1;
    chk("step_irw", ir_write, 1);
    @(negedge clk);
    chk("step_id", state, 1);
    wait_retire();
`endif
    run(6'h00, 6'h22, 1'b0);
    run(6'h23, 6'h00, 1'b0);
    run(6'h04, 6'h00, 1'b1);
    run(6'h04, 6'h00, 1'b0);
    run(6'h05, 6'h00, 1'b1);
    run(6'h05, 6'h00, 1'b0);
    run(6'h2B, 6'h00, 1'b0);
    run(6'h02, 6'h00, 1'b0);
    run(6'h0B, 6'h00, 1'b0);
    run(6'h0E, 6'h00, 1'b0);
    run(6'h3F, 6'h00, 1'b0);
    chk("illegal_sticky", illegal, 1);
    run(6'h00, 6'h01, 1'b0);
    run(6'h0C, 6'h00, 1'b0);
    do_reset();
    op = 6'h2B;
    for (int i = 0; i < 10 && state != 4'd4; i++) @(negedge clk);
    chk("sw_reach_ma", state, 4);
    rst = 1'b1;
    #1;
    chk("sw_rst_memw", mem_write, 0);
    @(posedge clk);
    #1;
    chk("sw_rst_state", state, 0);
    chk("sw_rst_memw2", mem_write, 0);
    rst = 1'b0;
    sticky = 1'b0;
    for (int k = 0; k < 80; k++) begin
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
      run(o, f, 1'($urandom));
      if (k % 20 == 19) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
